// File: rtl/text_string_plotter_pkg.sv
// Shared constants, glyph codes, FSM state type and the 8x16 A-P font
// used by the string plotter and its glyph ROM.
package text_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam int DEF_GLYPH_W = 8;
    localparam int DEF_GLYPH_H = 16;

    localparam int FONT_W      = 8;
    localparam int FONT_H      = 16;
    localparam int FONT_GLYPHS = 16;

    localparam int GLYPH_A = 0,  GLYPH_B = 1,  GLYPH_C = 2,  GLYPH_D = 3;
    localparam int GLYPH_E = 4,  GLYPH_F = 5,  GLYPH_G = 6,  GLYPH_H = 7;
    localparam int GLYPH_I = 8,  GLYPH_J = 9,  GLYPH_K = 10, GLYPH_L = 11;
    localparam int GLYPH_M = 12, GLYPH_N = 13, GLYPH_O = 14, GLYPH_P = 15;
    localparam int GLYPH_BLANK = FONT_GLYPHS;

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    // Row-major, row 0 in bits [127:120], MSB of each row byte = column 0.
    localparam logic [127:0] FONT [FONT_GLYPHS] = '{
        128'h0000_1824_4242_427E_4242_4242_4200_0000,
        128'h0000_7C42_4242_7C42_4242_427C_0000_0000,
        128'h0000_3C42_4040_4040_4040_423C_0000_0000,
        128'h0000_7844_4242_4242_4242_4478_0000_0000,
        128'h0000_7E40_4040_7C40_4040_407E_0000_0000,
        128'h0000_7E40_4040_7C40_4040_4040_0000_0000,
        128'h0000_3C42_4040_4E42_4242_463A_0000_0000,
        128'h0000_4242_4242_7E42_4242_4242_0000_0000,
        128'h0000_3E08_0808_0808_0808_083E_0000_0000,
        128'h0000_1E04_0404_0404_0444_4438_0000_0000,
        128'h0000_4244_4850_6060_5048_4442_0000_0000,
        128'h0000_4040_4040_4040_4040_407E_0000_0000,
        128'h0000_4266_5A5A_4242_4242_4242_0000_0000,
        128'h0000_4262_6252_524A_4A46_4642_0000_0000,
        128'h0000_3C42_4242_4242_4242_423C_0000_0000,
        128'h0000_7C42_4242_7C40_4040_4040_0000_0000
    };

endpackage

// File: rtl/text_string_plotter_if.sv
// Request/status and VGA pixel bundle between game logic, the string plotter
// and the VGA adapter.
interface text_string_plotter_if #(
    parameter int MAX_CHARS = 8,
    parameter int CODE_W    = 4,
    parameter int CNT_W     = 4,
    parameter int COLOUR_W  = 3
);
    logic                          start;
    logic [7:0]                    origin_x;
    logic [6:0]                    origin_y;
    logic [CNT_W-1:0]              char_count;
    logic [MAX_CHARS*CODE_W-1:0]   char_codes;
    logic [COLOUR_W-1:0]           fg_colour;
    logic [COLOUR_W-1:0]           bg_colour;
    logic                          opaque;
    logic                          hold;
    logic                          busy;
    logic                          done;
    logic [7:0]                    vga_x;
    logic [6:0]                    vga_y;
    logic [COLOUR_W-1:0]           vga_colour;
    logic                          vga_plot;

    modport master (
        output start, origin_x, origin_y, char_count, char_codes,
               fg_colour, bg_colour, opaque, hold,
        input  busy, done, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  start, origin_x, origin_y, char_count, char_codes,
               fg_colour, bg_colour, opaque, hold,
        output busy, done, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/text_string_plotter_glyph_rom.sv
// Combinational glyph ROM: returns one GLYPH_W-bit row word (MSB = column 0);
// codes beyond the font or NUM_GLYPHS read back as blank.
module glyph_rom
    import text_pkg::*;
#(
    parameter int GLYPH_W    = DEF_GLYPH_W,
    parameter int GLYPH_H    = DEF_GLYPH_H,
    parameter int NUM_GLYPHS = 16,
    parameter int CODE_W     = 4,
    parameter int ROW_W      = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1
) (
    input  logic [CODE_W-1:0]  code,
    input  logic [ROW_W-1:0]   row,
    output logic [GLYPH_W-1:0] row_bits
);
    localparam int NG = (NUM_GLYPHS < FONT_GLYPHS) ? NUM_GLYPHS : FONT_GLYPHS;
    localparam int NC = (GLYPH_W < FONT_W) ? GLYPH_W : FONT_W;
    localparam int NR = (GLYPH_H < FONT_H) ? GLYPH_H : FONT_H;

    always_comb begin
        row_bits = '0;
        for (int unsigned g = 0; g < NG; g++) begin
            for (int unsigned r = 0; r < NR; r++) begin
                if (code == CODE_W'(g) && row == ROW_W'(r)) begin
                    for (int unsigned c = 0; c < NC; c++)
                        row_bits[GLYPH_W-1-c] = FONT[g][FONT_W*(FONT_H-r)-1-c];
                end
            end
        end
    end
endmodule

// File: rtl/text_string_plotter.sv
// Draws a latched string of glyphs one pixel per clock into the 160x120 VGA
// framebuffer. Define TEXT_PLOTTER_CLIP_EN to suppress off-screen pixels.
module text_string_plotter
    import text_pkg::*;
#(
    parameter int GLYPH_W    = DEF_GLYPH_W,
    parameter int GLYPH_H    = DEF_GLYPH_H,
    parameter int NUM_GLYPHS = 16,
    parameter int MAX_CHARS  = 8,
    parameter int COLOUR_W   = 3,
    parameter int CODE_W     = $clog2(NUM_GLYPHS),
    parameter int CNT_W      = $clog2(MAX_CHARS + 1)
) (
    input logic               clk,
    input logic               resetn,
    text_string_plotter_if.slave bus
);
    localparam int COL_W = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int ROW_W = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;

    state_t                        r_state;
    logic [COL_W-1:0]              r_col;
    logic [ROW_W-1:0]              r_row;
    logic [CNT_W-1:0]              r_chr;
    logic [CNT_W-1:0]              r_count;
    logic [MAX_CHARS*CODE_W-1:0]   r_codes;
    logic [7:0]                    r_ox;
    logic [6:0]                    r_oy;
    logic [COLOUR_W-1:0]           r_fg, r_bg, r_colour;
    logic                          r_opaque, r_busy, r_done, r_plot;
    logic [7:0]                    r_x;
    logic [6:0]                    r_y;

    logic [CODE_W-1:0]  w_code;
    logic [GLYPH_W-1:0] w_row_bits;
    logic               w_bit, w_onscreen;
    logic [7:0]         w_x;
    logic [6:0]         w_y;

    always_comb begin
        w_code = '0;
        for (int unsigned i = 0; i < MAX_CHARS; i++)
            if (r_chr == CNT_W'(i)) w_code = r_codes[i*CODE_W +: CODE_W];
    end

    glyph_rom #(
        .GLYPH_W(GLYPH_W), .GLYPH_H(GLYPH_H), .NUM_GLYPHS(NUM_GLYPHS),
        .CODE_W(CODE_W), .ROW_W(ROW_W)
    ) u_rom (
        .code(w_code), .row(r_row), .row_bits(w_row_bits)
    );

    assign w_bit = w_row_bits[COL_W'(GLYPH_W - 1) - r_col];

`ifdef TEXT_PLOTTER_CLIP_EN
    logic [8:0] w_x9;
    logic [7:0] w_y8;
    assign w_x9       = 9'(int'(r_ox) + int'(r_chr) * GLYPH_W + int'(r_col));
    assign w_y8       = 8'(int'(r_oy) + int'(r_row));
    assign w_x        = w_x9[7:0];
    assign w_y        = w_y8[6:0];
    assign w_onscreen = (w_x9 < 9'(SCREEN_W)) && (w_y8 < 8'(SCREEN_H));
`else
    assign w_x        = 8'(int'(r_ox) + int'(r_chr) * GLYPH_W + int'(r_col));
    assign w_y        = 7'(int'(r_oy) + int'(r_row));
    assign w_onscreen = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_col    <= '0;
            r_row    <= '0;
            r_chr    <= '0;
            r_count  <= '0;
            r_codes  <= '0;
            r_ox     <= '0;
            r_oy     <= '0;
            r_fg     <= '0;
            r_bg     <= '0;
            r_opaque <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_plot   <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
        end else begin
            r_done <= 1'b0;
            r_plot <= 1'b0;
            case (r_state)
                IDLE: if (bus.start) begin
                    r_ox     <= bus.origin_x;
                    r_oy     <= bus.origin_y;
                    r_count  <= (bus.char_count > CNT_W'(MAX_CHARS)) ? CNT_W'(MAX_CHARS)
                                                                     : bus.char_count;
                    r_codes  <= bus.char_codes;
                    r_fg     <= bus.fg_colour;
                    r_bg     <= bus.bg_colour;
                    r_opaque <= bus.opaque;
                    r_col    <= '0;
                    r_row    <= '0;
                    r_chr    <= '0;
                    r_busy   <= 1'b1;
                    r_state  <= (bus.char_count == '0) ? DONE : DRAW;
                end
                DRAW: if (!bus.hold) begin
                    r_x      <= w_x;
                    r_y      <= w_y;
                    r_colour <= w_bit ? r_fg : r_bg;
                    r_plot   <= (w_bit | r_opaque) & w_onscreen;
                    if (r_col == COL_W'(GLYPH_W - 1)) begin
                        r_col <= '0;
                        if (r_row == ROW_W'(GLYPH_H - 1)) begin
                            r_row <= '0;
                            if (r_chr == r_count - CNT_W'(1)) begin
                                r_chr   <= '0;
                                r_state <= DONE;
                            end else begin
                                r_chr <= r_chr + CNT_W'(1);
                            end
                        end else begin
                            r_row <= r_row + ROW_W'(1);
                        end
                    end else begin
                        r_col <= r_col + COL_W'(1);
                    end
                end
                DONE: begin
                    // done and busy-low land together, one cycle after the last pixel
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.vga_x      = r_x;
    assign bus.vga_y      = r_y;
    assign bus.vga_colour = r_colour;
    assign bus.vga_plot   = r_plot;
endmodule

// File: tb/tb_text_string_plotter.sv
// Scoreboard bench for text_string_plotter: expected pixels are generated from
// an independent font copy when a draw is started and popped as plots appear.
module tb_text_string_plotter;

    localparam int MAXC = 8;
    localparam int CW   = 5;
    localparam int NW   = 4;
    localparam int COLW = 3;

    localparam logic [127:0] TB_FONT [16] = '{
        128'h0000_1824_4242_427E_4242_4242_4200_0000,
        128'h0000_7C42_4242_7C42_4242_427C_0000_0000,
        128'h0000_3C42_4040_4040_4040_423C_0000_0000,
        128'h0000_7844_4242_4242_4242_4478_0000_0000,
        128'h0000_7E40_4040_7C40_4040_407E_0000_0000,
        128'h0000_7E40_4040_7C40_4040_4040_0000_0000,
        128'h0000_3C42_4040_4E42_4242_463A_0000_0000,
        128'h0000_4242_4242_7E42_4242_4242_0000_0000,
        128'h0000_3E08_0808_0808_0808_083E_0000_0000,
        128'h0000_1E04_0404_0404_0444_4438_0000_0000,
        128'h0000_4244_4850_6060_5048_4442_0000_0000,
        128'h0000_4040_4040_4040_4040_407E_0000_0000,
        128'h0000_4266_5A5A_4242_4242_4242_0000_0000,
        128'h0000_4262_6252_524A_4A46_4642_0000_0000,
        128'h0000_3C42_4242_4242_4242_423C_0000_0000,
        128'h0000_7C42_4242_7C40_4040_4040_0000_0000
    };

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    text_string_plotter_if #(.MAX_CHARS(MAXC), .CODE_W(CW), .CNT_W(NW), .COLOUR_W(COLW)) bus();

    text_string_plotter #(.MAX_CHARS(MAXC), .COLOUR_W(COLW), .CODE_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );

    pix_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int obs_plots, busy_cnt, done_cnt, done_d, holds, first_x, first_y;

    function automatic logic [39:0] codes3(input int c0, input int c1, input int c2);
        return 40'({5'(c2), 5'(c1), 5'(c0)});
    endfunction

    task automatic model(input int ox, input int oy, input int cnt, input logic [39:0] codes,
                         input int fg, input int bg, input bit opq);
        int n;
        n = (cnt > MAXC) ? MAXC : cnt;
        for (int ch = 0; ch < n; ch++) begin
            logic [39:0]  t;
            logic [127:0] g;
            int           code;
            t    = codes >> (5 * ch);
            code = int'(t[4:0]);
            g    = (code < 16) ? TB_FONT[4'(code)] : '0;
            for (int r = 0; r < 16; r++) begin
                for (int c = 0; c < 8; c++) begin
                    logic [127:0] s;
                    bit b, plot;
                    int x, y;
                    pix_t p;
                    s    = g << (8 * r + c);
                    b    = s[127];
                    x    = ox + ch * 8 + c;
                    y    = oy + r;
                    plot = b | opq;
`ifdef TEXT_PLOTTER_CLIP_EN
                    if (x >= 160 || y >= 120) plot = 1'b0;
`endif
                    if (plot) begin
                        p.x = 8'(x);
                        p.y = 7'(y);
                        p.c = b ? 3'(fg) : 3'(bg);
                        exp_q.push_back(p);
                    end
                end
            end
        end
    endtask

    task automatic start_draw(input int ox, input int oy, input int cnt, input logic [39:0] codes,
                              input int fg, input int bg, input bit opq);
        @(negedge clk);
        bus.origin_x   = 8'(ox);
        bus.origin_y   = 7'(oy);
        bus.char_count = NW'(cnt);
        bus.char_codes = codes;
        bus.fg_colour  = 3'(fg);
        bus.bg_colour  = 3'(bg);
        bus.opaque     = opq;
        bus.start      = 1'b1;
        model(ox, oy, cnt, codes, fg, bg, opq);
    endtask

    // Runs one accepted draw; d counts clock edges after the accepting edge.
    task automatic collect(input int maxc, input bit hold_mode, input int intrude_d);
        pix_t o, e;
        obs_plots = 0; busy_cnt = 0; done_cnt = 0; done_d = -1; holds = 0;
        first_x = -1; first_y = -1;
        for (int d = 0; d < maxc; d++) begin
            @(negedge clk);
            bus.start = (d == intrude_d);
            if (d == 0) begin
                bus.origin_x   = 8'($urandom);
                bus.origin_y   = 7'($urandom);
                bus.char_count = NW'($urandom);
                bus.char_codes = 40'({$urandom, $urandom});
                bus.fg_colour  = 3'($urandom);
                bus.bg_colour  = 3'($urandom);
                bus.opaque     = 1'($urandom);
            end
            if (bus.vga_plot) begin
                o = '{x: bus.vga_x, y: bus.vga_y, c: bus.vga_colour};
                if (obs_plots == 0) begin first_x = int'(o.x); first_y = int'(o.y); end
                obs_plots++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL pixel_extra: got x=%0d y=%0d c=%0d, expected no plot", o.x, o.y, o.c);
                end else begin
                    e = exp_q.pop_front();
                    if (o !== e) begin
                        n_err++;
                        $display("FAIL pixel: got x=%0d y=%0d c=%0d, expected x=%0d y=%0d c=%0d",
                                 o.x, o.y, o.c, e.x, e.y, e.c);
                    end
                end
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_d < 0) done_d = d;
            end
            if (done_d >= 0 && d >= done_d + 3) break;
            bus.hold = hold_mode && (d + 1 <= 90) && ((d + 1) % 3 == 0);
            if (bus.hold) holds++;
        end
        bus.hold  = 1'b0;
        bus.start = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pixels_missing: %0d expected plots never appeared, required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        int dc, pc;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.done, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour} !== '0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b plot=%b x=%0d y=%0d c=%0d, required all 0",
                     bus.busy, bus.done, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour);
        end
        @(negedge clk);
        resetn = 1'b1;
        start_draw(20, 30, 2, codes3(1, 0, 0), 5, 2, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (40) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.vga_plot !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL midreset: busy=%b plot=%b done=%b, required 0 0 0", bus.busy, bus.vga_plot, bus.done);
        end
        resetn = 1'b1;
        exp_q.delete();
        dc = 0; pc = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.done) dc++;
            if (bus.vga_plot) pc++;
        end
        n_cmp++;
        if (dc != 0 || pc != 0) begin
            n_err++;
            $display("FAIL midreset_aftermath: done=%0d plots=%0d, required 0 0", dc, pc);
        end
        start_draw(0, 100, 1, codes3(1, 0, 0), 6, 0, 1'b0);
        collect(400, 1'b0, -1);
        n_cmp++;
        if (done_d != 129 || done_cnt != 1) begin
            n_err++;
            $display("FAIL redraw_after_reset: done at %0d count %0d, required 129 1", done_d, done_cnt);
        end
    endtask

    task automatic test_single_a();
        start_draw(10, 20, 1, codes3(0, 0, 0), 4, 0, 1'b0);
        collect(400, 1'b0, -1);
        n_cmp++;
        if (obs_plots != 26) begin n_err++; $display("FAIL a_plots: got %0d, required 26", obs_plots); end
        n_cmp++;
        if (first_x != 13 || first_y != 22) begin
            n_err++; $display("FAIL a_first: got (%0d,%0d), required (13,22)", first_x, first_y);
        end
        n_cmp++;
        if (busy_cnt != 129) begin n_err++; $display("FAIL a_busy: got %0d, required 129", busy_cnt); end
        n_cmp++;
        if (done_cnt != 1 || done_d != 129) begin
            n_err++; $display("FAIL a_done: count %0d at %0d, required 1 at 129", done_cnt, done_d);
        end
    endtask

    task automatic test_string_opaque();
        start_draw(0, 0, 3, codes3(0, 1, 2), 7, 1, 1'b1);
        collect(800, 1'b0, -1);
        n_cmp++;
        if (obs_plots != 384) begin n_err++; $display("FAIL abc_plots: got %0d, required 384", obs_plots); end
        n_cmp++;
        if (done_d != 385) begin n_err++; $display("FAIL abc_done: got %0d, required 385", done_d); end
    endtask

    task automatic test_empty_and_blank();
        start_draw(5, 5, 0, codes3(0, 0, 0), 7, 1, 1'b1);
        collect(50, 1'b0, -1);
        n_cmp++;
        if (obs_plots != 0 || done_d != 1 || busy_cnt != 1) begin
            n_err++;
            $display("FAIL empty: plots=%0d done_at=%0d busy=%0d, required 0 1 1", obs_plots, done_d, busy_cnt);
        end
        start_draw(30, 40, 1, codes3(20, 0, 0), 7, 1, 1'b0);
        collect(400, 1'b0, -1);
        n_cmp++;
        if (obs_plots != 0 || done_d != 129) begin
            n_err++; $display("FAIL blank_code: plots=%0d done_at=%0d, required 0 129", obs_plots, done_d);
        end
        start_draw(0, 60, 12, 40'({5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0}), 2, 0, 1'b0);
        collect(2000, 1'b0, -1);
        n_cmp++;
        if (done_d != 1025) begin n_err++; $display("FAIL saturate: done_at=%0d, required 1025", done_d); end
    endtask

    task automatic test_hold();
        int ref_done, ref_plots;
        start_draw(40, 50, 1, codes3(8, 0, 0), 3, 0, 1'b0);
        collect(400, 1'b0, -1);
        ref_done = done_d; ref_plots = obs_plots;
        start_draw(40, 50, 1, codes3(8, 0, 0), 3, 0, 1'b0);
        collect(400, 1'b1, 50);
        n_cmp++;
        if (holds != 30 || done_d != ref_done + holds) begin
            n_err++;
            $display("FAIL hold_timing: done_at=%0d holds=%0d, required %0d with 30 holds", done_d, holds, ref_done + 30);
        end
        n_cmp++;
        if (obs_plots != ref_plots || done_cnt != 1) begin
            n_err++;
            $display("FAIL hold_plots: plots=%0d dones=%0d, required %0d 1", obs_plots, done_cnt, ref_plots);
        end
    endtask

    task automatic test_wrap_clip();
        int want;
`ifdef TEXT_PLOTTER_CLIP_EN
        want = 12;
`else
        want = 24;
`endif
        start_draw(156, 10, 1, codes3(7, 0, 0), 5, 0, 1'b0);
        collect(400, 1'b0, -1);
        n_cmp++;
        if (obs_plots != want || done_d != 129) begin
            n_err++;
            $display("FAIL edge_h: plots=%0d done_at=%0d, required %0d 129", obs_plots, done_d, want);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.hold = 1'b0; bus.opaque = 1'b0;
        bus.origin_x = '0; bus.origin_y = '0; bus.char_count = '0;
        bus.char_codes = '0; bus.fg_colour = '0; bus.bg_colour = '0;
        test_reset();
        test_single_a();
        test_string_opaque();
        test_empty_and_blank();
        test_hold();
        test_wrap_clip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
